fc_weight_bank: RTL
===================

Name: fc_weight_bank

Overview:
Parametrised weight store for the fully connected layer, holding a full NUM_OUTPUTS x FLATTENED_LENGTH weight matrix instead of a single weight vector. Weights stream in one per cycle over a valid/ready handshake in row-major order. A single neuron's full weight row is then read out in parallel with 1-cycle latency. Sits between the weight-load interface and the fully connected MAC array.

Parameters:
FLATTENED_LENGTH, 50, weights per neuron row (flattened input length); must be >= 2
FULLYCONNECTED_DATA_WIDTH, 8, bits per weight
NUM_OUTPUTS, 10, neuron rows stored; must be >= 2
NIDX_W, $clog2(NUM_OUTPUTS), width of neuron index (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
load_start  in  1  pulse: begin a full matrix load
wt_valid  in  1  weight on wt_data is valid
wt_data  in  FULLYCONNECTED_DATA_WIDTH  streamed weight, row-major
wt_ready  out  1  bank accepts a weight this cycle
loaded  out  1  matrix completely loaded, reads permitted
rd_req  in  1  read request for one neuron row
rd_neuron  in  NIDX_W  neuron row index to read
rd_valid  out  1  rd_weights holds requested row (1-cycle pulse)
rd_err  out  1  out-of-range rd_neuron (1-cycle pulse)
rd_weights  out  FULLYCONNECTED_DATA_WIDTH x FLATTENED_LENGTH (unpacked array)  row read data

Behaviour:
- Reset (rst=0, async): state=IDLE; storage, col/row counters, rd_weights all 0; wt_ready=0, loaded=0, rd_valid=0, rd_err=0.
- States: IDLE, LOAD, READY (plus LOAD_BIAS under FC_BIAS_EN).
- IDLE: wt_ready=0. load_start -> LOAD next cycle. rd_req ignored.
- LOAD: wt_ready=1 (combinational from state). Entry clears row=0, col=0, loaded=0.
  - Handshake (wt_valid & wt_ready) writes mem[row][col]=wt_data.
  - On each handshake col increments. When col==FLATTENED_LENGTH-1, col wraps to 0 and row increments.
  - Handshake at row==NUM_OUTPUTS-1, col==FLATTENED_LENGTH-1 -> READY; loaded=1 from the next cycle.
  - wt_valid low: counters hold (stalls allowed indefinitely).
  - load_start while in LOAD: ignored; no restart.
  - rd_req while in LOAD: ignored; no rd_valid, no rd_err.
- READY: wt_ready=0, loaded=1.
  - rd_req with rd_neuron < NUM_OUTPUTS: next cycle rd_weights=mem[rd_neuron], rd_valid=1 for 1 cycle.
  - rd_req with rd_neuron >= NUM_OUTPUTS: next cycle rd_err=1 for 1 cycle, rd_valid=0, rd_weights holds.
  - Back-to-back rd_req every cycle is supported; each yields its own result 1 cycle later.
  - load_start -> LOAD (reload, overwrites in place). load_start takes priority over a simultaneous rd_req; that read is dropped.
- rd_weights holds its last value between reads. It is not cleared by reload, only by reset.
- Reset mid-load: partial data discarded, storage zeroed, IDLE.

Optional Feature:
FC_BIAS_EN
- Defined:
  - Adds a per-neuron bias store (NUM_OUTPUTS x FULLYCONNECTED_DATA_WIDTH) and output port rd_bias (FULLYCONNECTED_DATA_WIDTH).
  - After the last weight handshake, the FSM enters LOAD_BIAS instead of READY. In LOAD_BIAS, wt_ready=1 and NUM_OUTPUTS further handshakes fill bias[0..NUM_OUTPUTS-1]; the last one -> READY.
  - rd_bias updates together with rd_weights and has the same latency.
  - Bias storage and rd_bias reset to 0.
- Undefined: no LOAD_BIAS state, no bias storage, no rd_bias port.

Test Plan:
- Reset/idle: assert rst=0 mid-simulation -> all outputs 0, loaded=0, wt_ready=0. rd_req in IDLE -> no rd_valid/rd_err.
- Full load, defaults: load_start, then 500 weights wt_data=i%256 with wt_valid held high -> loaded=1 exactly 1 cycle after the 500th handshake. rd_neuron=3 -> next cycle rd_valid=1, rd_weights[k]=(150+k)%256.
- Stalled load: toggle wt_valid every other cycle across the row-3/row-4 boundary -> no skipped or duplicated writes. Rows 3 and 4 match the sequential pattern.
- Out-of-range and back-to-back reads: rd_neuron=12 -> rd_err=1 for 1 cycle, rd_weights unchanged. Then rd_req for rows 0,9,0 on consecutive cycles -> three rd_valid pulses with the matching rows.
- Reload/priority: in READY, load_start and rd_req asserted together -> no rd_valid, loaded=0. Reload all weights=8'hA5 -> any row reads all A5.
- Reset mid-load: rst=0 after 37 weights -> IDLE, storage 0. Reload weights=i%256 and read row 0 -> rd_weights[k]=k. Under FC_BIAS_EN, bias values 200..209 -> rd_neuron=5 gives rd_bias=205.

Source files
------------

// File: rtl/fc_weight_bank.sv
// Weight store for the fully connected layer: streams a NUM_OUTPUTS x FLATTENED_LENGTH matrix in
// row-major order, then serves whole neuron rows with 1-cycle latency. Optional FC_BIAS_EN adds a per-neuron bias store.
module fc_weight_bank #(
  parameter int FLATTENED_LENGTH          = 50,
  parameter int FULLYCONNECTED_DATA_WIDTH = 8,
  parameter int NUM_OUTPUTS               = 10,
  parameter int NIDX_W                    = $clog2(NUM_OUTPUTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_start,
  input  logic                                 wt_valid,
  input  logic [FULLYCONNECTED_DATA_WIDTH-1:0] wt_data,
  output logic                                 wt_ready,
  output logic                                 loaded,
  input  logic                                 rd_req,
  input  logic [NIDX_W-1:0]                    rd_neuron,
  output logic                                 rd_valid,
  output logic                                 rd_err,
`ifdef FC_BIAS_EN
  output logic [FULLYCONNECTED_DATA_WIDTH-1:0] rd_bias,
`endif
  output logic [FULLYCONNECTED_DATA_WIDTH-1:0] rd_weights [FLATTENED_LENGTH]
);

  localparam int COL_W = $clog2(FLATTENED_LENGTH);
  localparam int DW    = FULLYCONNECTED_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_READY
`ifdef FC_BIAS_EN
    , S_LOAD_BIAS
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [NIDX_W-1:0] row_q, row_d;
  logic [DW-1:0]     mem_q [NUM_OUTPUTS][FLATTENED_LENGTH];
  logic [DW-1:0]     rd_w_q [FLATTENED_LENGTH];
  logic              rd_valid_q, rd_err_q;

  logic              hs, last_col, last_row, start_ok, rd_ok, in_range;
  logic [NIDX_W-1:0] rd_idx;

  assign hs       = wt_valid & wt_ready;
  assign last_col = (col_q == COL_W'(FLATTENED_LENGTH-1));
  assign last_row = (row_q == NIDX_W'(NUM_OUTPUTS-1));
  assign start_ok = load_start & ((state_q == S_IDLE) | (state_q == S_READY));
  // load_start wins over a same-cycle read request
  assign rd_ok    = rd_req & ~load_start & (state_q == S_READY);
  assign in_range = (32'(rd_neuron) < NUM_OUTPUTS);
  assign rd_idx   = in_range ? rd_neuron : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_start) state_d = S_LOAD;
      S_LOAD:
        if (hs && last_col && last_row) begin
`ifdef FC_BIAS_EN
          state_d = S_LOAD_BIAS;
`else
          state_d = S_READY;
`endif
        end
`ifdef FC_BIAS_EN
      S_LOAD_BIAS: if (hs && last_row) state_d = S_READY;
`endif
      S_READY: if (load_start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wt_ready = 1'b0;
    loaded   = 1'b0;
    case (state_q)
      S_LOAD:      wt_ready = 1'b1;
`ifdef FC_BIAS_EN
      S_LOAD_BIAS: wt_ready = 1'b1;
`endif
      S_READY:     loaded   = 1'b1;
      default:     ;
    endcase
  end

  // Counters: row doubles as the bias index during the bias phase.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (start_ok) begin
      row_d = '0;
      col_d = '0;
    end else if (hs && state_q == S_LOAD) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
`ifdef FC_BIAS_EN
    else if (hs && state_q == S_LOAD_BIAS) begin
      row_d = last_row ? '0 : row_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q      <= '0;
      col_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      for (int r = 0; r < NUM_OUTPUTS; r++)
        for (int c = 0; c < FLATTENED_LENGTH; c++)
          mem_q[r][c] <= '0;
      for (int c = 0; c < FLATTENED_LENGTH; c++)
        rd_w_q[c] <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      rd_valid_q <= rd_ok & in_range;
      rd_err_q   <= rd_ok & ~in_range;
      if (hs && state_q == S_LOAD)
        mem_q[row_q][col_q] <= wt_data;
      if (rd_ok && in_range)
        rd_w_q <= mem_q[rd_idx];
    end
  end

`ifdef FC_BIAS_EN
  logic [DW-1:0] bias_q [NUM_OUTPUTS];
  logic [DW-1:0] rd_bias_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bias_q <= '0;
      for (int r = 0; r < NUM_OUTPUTS; r++) bias_q[r] <= '0;
    end else begin
      if (hs && state_q == S_LOAD_BIAS)
        bias_q[row_q] <= wt_data;
      if (rd_ok && in_range)
        rd_bias_q <= bias_q[rd_idx];
    end
  end

  assign rd_bias = rd_bias_q;
`endif

  assign rd_valid   = rd_valid_q;
  assign rd_err     = rd_err_q;
  assign rd_weights = rd_w_q;

endmodule
